// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// Module : cdb_arbiter_pkg
// Brief  : Shared widths and helpers for the common data bus arbiter.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cdb_arbiter_pkg;

  localparam int              c_lock_w  = 5;
  localparam int              c_data_w  = 32;
  localparam logic [4:0]      c_no_lock = 5'h10;

  // A single producer still needs a one-bit source field.
  function automatic int cdb_src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_arb_fifo.sv
// ---------------------------------------------------------------------------
// Module : cdb_arb_fifo
// Brief  : Per-producer result FIFO with registered full/empty and flush.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cdb_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int               c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full  = (c_ptr_w + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full   = (r_count == c_full);
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{c_ptr_w{1'b0}}, w_push} - {{c_ptr_w{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// Module : cdb_arbiter
// Brief  : Round-robin arbiter sharing one registered CDB among N producers.
//          Optional macro CDB_ARB_STATS_EN adds per-producer grant/stall counters.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int               N_REQ      = 2,
  parameter int               LOCK_W     = c_lock_w,
  parameter int               DATA_W     = c_data_w,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [LOCK_W-1:0] NO_LOCK   = c_no_lock
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ*LOCK_W-1:0]           req_index,
  input  logic [N_REQ*DATA_W-1:0]           req_result,
  output logic [N_REQ-1:0]                  req_ready,
  output logic                              cdb_valid,
  output logic [LOCK_W-1:0]                 cdb_index,
  output logic [DATA_W-1:0]                 cdb_result,
  output logic [cdb_src_width(N_REQ)-1:0]   cdb_src
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]               grant_cnt,
  output logic [N_REQ*16-1:0]               stall_cnt
`endif
);

  localparam int c_src_w = cdb_src_width(N_REQ);
  localparam int c_ent_w = LOCK_W + DATA_W;

  logic [N_REQ-1:0]   w_full;
  logic [N_REQ-1:0]   w_empty;
  logic [N_REQ-1:0]   w_push;
  logic [N_REQ-1:0]   w_pop;
  logic [c_ent_w-1:0] w_head [N_REQ];
  logic [c_ent_w-1:0] w_head_sel;
  logic [c_src_w-1:0] w_grant;
  logic [c_src_w-1:0] w_rr_next;
  logic               w_grant_vld;
  int                 w_scan;

  logic [c_src_w-1:0] r_rr_ptr;
  logic               r_cdb_valid;
  logic [LOCK_W-1:0]  r_cdb_index;
  logic [DATA_W-1:0]  r_cdb_result;
  logic [c_src_w-1:0] r_cdb_src;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fifo
      // NO_LOCK results carry nothing to wake up, so they are consumed but dropped.
      assign w_push[gi] = req_valid[gi] & ~w_full[gi] & ~flush
                        & (req_index[gi*LOCK_W +: LOCK_W] != NO_LOCK);
      assign w_pop[gi]  = w_grant_vld & ~flush & (w_grant == c_src_w'(gi));

      cdb_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ent_w)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_push[gi]),
        .pop   (w_pop[gi]),
        .din   ({req_index[gi*LOCK_W +: LOCK_W], req_result[gi*DATA_W +: DATA_W]}),
        .full  (w_full[gi]),
        .empty (w_empty[gi]),
        .head  (w_head[gi])
      );
    end
  endgenerate

  assign req_ready = ~w_full;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_scan      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan = int'(r_rr_ptr) + k;
      if (w_scan >= N_REQ) w_scan = w_scan - N_REQ;
      if (!w_grant_vld && !w_empty[w_scan]) begin
        w_grant_vld = 1'b1;
        w_grant     = c_src_w'(w_scan);
      end
    end
  end

  assign w_head_sel = w_head[w_grant];
  assign w_rr_next  = (w_grant == c_src_w'(N_REQ - 1)) ? '0 : w_grant + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr     <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_index  <= NO_LOCK;
      r_cdb_result <= '0;
      r_cdb_src    <= '0;
    end else if (flush) begin
      r_rr_ptr     <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_index  <= NO_LOCK;
      r_cdb_result <= '0;
      r_cdb_src    <= '0;
    end else if (w_grant_vld) begin
      r_rr_ptr     <= w_rr_next;
      r_cdb_valid  <= 1'b1;
      r_cdb_index  <= w_head_sel[c_ent_w-1:DATA_W];
      r_cdb_result <= w_head_sel[DATA_W-1:0];
      r_cdb_src    <= w_grant;
    end else begin
      r_cdb_valid  <= 1'b0;
      r_cdb_index  <= NO_LOCK;
      r_cdb_result <= '0;
      r_cdb_src    <= '0;
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_index  = r_cdb_index;
  assign cdb_result = r_cdb_result;
  assign cdb_src    = r_cdb_src;

`ifdef CDB_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
      logic [15:0] r_grant_cnt;
      logic [15:0] r_stall_cnt;

      // Counters survive flush so statistics span pipeline recoveries.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_grant_cnt <= '0;
          r_stall_cnt <= '0;
        end else begin
          if (w_pop[gi] && (r_grant_cnt != 16'hFFFF))
            r_grant_cnt <= r_grant_cnt + 16'd1;
          if (req_valid[gi] && w_full[gi] && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
      end

      assign grant_cnt[gi*16 +: 16] = r_grant_cnt;
      assign stall_cnt[gi*16 +: 16] = r_stall_cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// Module : tb_cdb_arbiter
// Brief  : Scoreboard bench for cdb_arbiter (N_REQ=2, depth 2).
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [9:0]  req_index = '0;
  logic [63:0] req_result = '0;
  logic [1:0]  req_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_index;
  logic [31:0] cdb_result;
  logic [0:0]  cdb_src;
`ifdef CDB_ARB_STATS_EN
  logic [31:0] grant_cnt;
  logic [31:0] stall_cnt;
`endif

  cdb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_index  (req_index),
    .req_result (req_result),
    .req_ready  (req_ready),
    .cdb_valid  (cdb_valid),
    .cdb_index  (cdb_index),
    .cdb_result (cdb_result),
    .cdb_src    (cdb_src)
`ifdef CDB_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          bcast_total = 0;
  int          bcast_src1 = 0;
  logic [36:0] exp_a [$];
  logic [36:0] exp_l [$];
  logic        src_log [$];
  logic [36:0] mon_e;
  logic        mon_has;

  // Scoreboard: every broadcast must match the oldest expected entry of its source.
  always @(negedge clk) begin
    if (rst && cdb_valid) begin
      bcast_total++;
      if (cdb_src == 1'b1) bcast_src1++;
      src_log.push_back(cdb_src[0]);
      n_checks++;
      mon_has = 1'b0;
      if (cdb_src == 1'b0 && exp_a.size() != 0) begin
        mon_e = exp_a.pop_front(); mon_has = 1'b1;
      end else if (cdb_src == 1'b1 && exp_l.size() != 0) begin
        mon_e = exp_l.pop_front(); mon_has = 1'b1;
      end
      if (!mon_has)
        $display("FAIL bcast_unexpected: got src=%0d idx=%h result=%h, expected no broadcast",
                 cdb_src, cdb_index, cdb_result);
      else if ({cdb_index, cdb_result} !== mon_e)
        $display("FAIL bcast_data: src=%0d got idx=%h result=%h, expected idx=%h result=%h",
                 cdb_src, cdb_index, cdb_result, mon_e[36:32], mon_e[31:0]);
      else
        n_pass++;
    end
  end

  task automatic drive_streams(input int n_a, input int n_l, input logic [4:0] ia,
                               input logic [4:0] il, input logic [31:0] ra, input logic [31:0] rl);
    int ka = 0;
    int kl = 0;
    int guard = 0;
    while ((ka < n_a || kl < n_l) && guard < 40) begin
      @(negedge clk);
      req_valid[0]       = (ka < n_a);
      req_index[4:0]     = ia + 5'(ka);
      req_result[31:0]   = ra + 32'(ka);
      req_valid[1]       = (kl < n_l);
      req_index[9:5]     = il + 5'(kl);
      req_result[63:32]  = rl + 32'(kl);
      if (req_valid[0] && req_ready[0]) begin
        exp_a.push_back({req_index[4:0], req_result[31:0]}); ka++;
      end
      if (req_valid[1] && req_ready[1]) begin
        exp_l.push_back({req_index[9:5], req_result[63:32]}); kl++;
      end
      guard++;
    end
    @(negedge clk);
    req_valid = 2'b00;
    n_checks++;
    if (ka != n_a || kl != n_l)
      $display("FAIL stream_accept: accepted alu=%0d lsm=%0d, expected %0d/%0d", ka, kl, n_a, n_l);
    else n_pass++;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_a.size() != 0 || exp_l.size() != 0) && t < 30) begin
      @(negedge clk); #1; t++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_a.size() != 0 || exp_l.size() != 0)
      $display("FAIL drain: pending alu=%0d lsm=%0d, expected 0/0", exp_a.size(), exp_l.size());
    else n_pass++;
  endtask

  task automatic flush_cycle();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if ({cdb_valid, cdb_index, cdb_result, cdb_src} !== {1'b0, 5'h10, 32'h0, 1'b0})
      $display("FAIL reset_outputs: got v=%b idx=%h res=%h src=%b, expected v=0 idx=10 res=0 src=0",
               cdb_valid, cdb_index, cdb_result, cdb_src);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, cdb_valid} !== 3'b110)
      $display("FAIL reset_ready: got ready=%b v=%b, expected ready=11 v=0", req_ready, cdb_valid);
    else n_pass++;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 2'b01; req_index[4:0] = 5'd3; req_result[31:0] = 32'h0000_0005;
    exp_a.push_back({5'd3, 32'h5});
    @(negedge clk);
    req_valid = 2'b00;
    n_checks++;
    if (cdb_valid !== 1'b0) $display("FAIL single_early: got v=%b, expected 0", cdb_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({cdb_valid, cdb_index, cdb_result, cdb_src} !== {1'b1, 5'd3, 32'h5, 1'b0})
      $display("FAIL single_bcast: got v=%b idx=%h res=%h src=%b, expected v=1 idx=03 res=5 src=0",
               cdb_valid, cdb_index, cdb_result, cdb_src);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({cdb_valid, cdb_index} !== {1'b0, 5'h10})
      $display("FAIL single_after: got v=%b idx=%h, expected v=0 idx=10", cdb_valid, cdb_index);
    else n_pass++;
  endtask

  task automatic test_contention();
    flush_cycle();
    src_log.delete();
    drive_streams(4, 4, 5'd1, 5'd9, 32'h100, 32'h200);
    wait_drain();
    n_checks++;
    if (src_log.size() != 8)
      $display("FAIL contention_count: got %0d broadcasts, expected 8", src_log.size());
    else if ({src_log[0], src_log[1], src_log[2], src_log[3]} !== 4'b0101)
      $display("FAIL contention_order: got %b%b%b%b, expected 0101",
               src_log[0], src_log[1], src_log[2], src_log[3]);
    else n_pass++;
  endtask

  task automatic test_full();
    int base;
    flush_cycle();
    base = bcast_src1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b11) $display("FAIL full_ready_start: got %b, expected 11", req_ready);
    else n_pass++;
    req_valid = 2'b11;
    req_index = {5'd13, 5'd6}; req_result = {32'h130, 32'h60};
    exp_a.push_back({5'd6, 32'h60}); exp_l.push_back({5'd13, 32'h130});
    @(negedge clk);
    req_index = {5'd14, 5'd7}; req_result = {32'h131, 32'h61};
    exp_a.push_back({5'd7, 32'h61}); exp_l.push_back({5'd14, 32'h131});
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) $display("FAIL full_lsm_blocked: got ready=%b, expected 01", req_ready);
    else n_pass++;
    req_valid = 2'b10;
    req_index[9:5] = 5'd15; req_result[63:32] = 32'h132;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b11) $display("FAIL full_lsm_reopen: got ready=%b, expected 11", req_ready);
    else n_pass++;
    exp_l.push_back({5'd15, 32'h132});
    @(negedge clk);
    req_valid = 2'b00;
    wait_drain();
    n_checks++;
    if (bcast_src1 - base != 3)
      $display("FAIL full_lsm_total: got %0d lsm broadcasts, expected 3", bcast_src1 - base);
    else n_pass++;
  endtask

  task automatic test_nolock_flush();
    int base;
    base = bcast_total;
    @(negedge clk);
    req_valid = 2'b01; req_index[4:0] = 5'h10; req_result[31:0] = 32'hDEAD;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bcast_total != base)
      $display("FAIL nolock_dropped: got %0d broadcasts, expected 0", bcast_total - base);
    else n_pass++;
    drive_streams(1, 0, 5'd4, 5'd0, 32'h44, 32'h0);
    wait_drain();
    base = bcast_total;
    @(negedge clk);
    req_valid = 2'b11; req_index = {5'd14, 5'd5}; req_result = {32'h55, 32'h50};
    @(negedge clk);
    flush = 1'b1;
    req_valid = 2'b01; req_index[4:0] = 5'd21; req_result[31:0] = 32'hBAD;
    @(negedge clk);
    flush = 1'b0; req_valid = 2'b00;
    n_checks++;
    if ({req_ready, cdb_valid} !== 3'b110)
      $display("FAIL flush_state: got ready=%b v=%b, expected ready=11 v=0", req_ready, cdb_valid);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bcast_total != base)
      $display("FAIL flush_discard: got %0d broadcasts, expected 0", bcast_total - base);
    else n_pass++;
    req_valid = 2'b11; req_index = {5'd15, 5'd6}; req_result = {32'h77, 32'h66};
    exp_a.push_back({5'd6, 32'h66}); exp_l.push_back({5'd15, 32'h77});
    @(negedge clk);
    req_valid = 2'b00;
    n_checks++;
    if (cdb_valid !== 1'b0) $display("FAIL flush_next_early: got v=%b, expected 0", cdb_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({cdb_valid, cdb_src, cdb_index} !== {1'b1, 1'b0, 5'd6})
      $display("FAIL flush_rr_reset: got v=%b src=%b idx=%h, expected v=1 src=0 idx=06",
               cdb_valid, cdb_src, cdb_index);
    else n_pass++;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int base;
    @(negedge clk);
    req_valid = 2'b11; req_index = {5'd11, 5'd2}; req_result = {32'h110, 32'h20};
    exp_a.push_back({5'd2, 32'h20}); exp_l.push_back({5'd11, 32'h110});
    @(negedge clk);
    req_index = {5'd12, 5'd3}; req_result = {32'h111, 32'h21};
    exp_a.push_back({5'd3, 32'h21}); exp_l.push_back({5'd12, 32'h111});
    @(negedge clk);
    req_valid = 2'b00;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({cdb_valid, cdb_index, cdb_result, cdb_src} !== {1'b0, 5'h10, 32'h0, 1'b0})
      $display("FAIL reset_mid_outputs: got v=%b idx=%h res=%h src=%b, expected v=0 idx=10 res=0 src=0",
               cdb_valid, cdb_index, cdb_result, cdb_src);
    else n_pass++;
    exp_a.delete(); exp_l.delete();
    base = bcast_total;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b11) $display("FAIL reset_mid_ready: got %b, expected 11", req_ready);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bcast_total != base)
      $display("FAIL reset_mid_stale: got %0d broadcasts, expected 0", bcast_total - base);
    else n_pass++;
  endtask

`ifdef CDB_ARB_STATS_EN
  task automatic test_stats();
    n_checks++;
    if ({grant_cnt, stall_cnt} !== 64'h0)
      $display("FAIL stats_reset: got grant=%h stall=%h, expected 0/0", grant_cnt, stall_cnt);
    else n_pass++;
    drive_streams(3, 4, 5'd20, 5'd24, 32'h300, 32'h400);
    wait_drain();
    n_checks++;
    if ({grant_cnt, stall_cnt} !== {16'd4, 16'd3, 16'd2, 16'd0})
      $display("FAIL stats_counts: got grant=%h stall=%h, expected grant=00040003 stall=00020000",
               grant_cnt, stall_cnt);
    else n_pass++;
    flush_cycle();
    @(negedge clk);
    n_checks++;
    if ({grant_cnt, stall_cnt} !== {16'd4, 16'd3, 16'd2, 16'd0})
      $display("FAIL stats_flush: got grant=%h stall=%h, expected grant=00040003 stall=00020000",
               grant_cnt, stall_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_nolock_flush();
    test_reset_mid();
`ifdef CDB_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
